mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single shared memory port of the multicycle CPU. It grants the port to either the CPU (instruction fetch and load/store accesses, i.e. the MemRead/MemWrite/IorD path) or a DMA requester. It drives the memory strobes for a fixed access latency, captures read data, and returns a one-cycle completion pulse to the granted requester. It sits between the CPU datapath/control and the external memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter: FSM state encoding,
//   owner encoding and the default data/address width.
package mem_port_arbiter_pkg;

   localparam int WORD_SIZE = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection for the shared memory port.
//   Build option: MEM_ARB_RR_EN selects round-robin tie breaking using the
//   last owner; without it the CPU always wins a tie.
// Ports:
//   cpu_req, dma_req  request levels
//   last_owner        requester served last (MEM_ARB_RR_EN builds only)
//   any_req           at least one request present
//   winner            requester to be granted
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic   cpu_req,
   input  logic   dma_req,
`ifdef MEM_ARB_RR_EN
   input  owner_t last_owner,
`endif
   output logic   any_req,
   output owner_t winner
);

   always_comb begin
      any_req = cpu_req | dma_req;
      winner  = OWN_CPU;
      if (dma_req && !cpu_req) begin
         winner = OWN_DMA;
      end
`ifdef MEM_ARB_RR_EN
      else if (dma_req && cpu_req && (last_owner == OWN_CPU)) begin
         winner = OWN_DMA;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Grants the single memory port to the CPU or the DMA requester, holds the
//   memory strobe for MEM_LATENCY cycles, captures read data and returns a
//   one-cycle ready pulse to the owner. All outputs are registered.
//   Build option: MEM_ARB_RR_EN enables round-robin tie breaking (otherwise
//   fixed CPU priority and no last-owner register).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request side
//   cpu_rdata, cpu_ready            CPU read data and completion pulse
//   dma_req/we/addr/wdata           DMA request side
//   dma_rdata, dma_ready            DMA read data and completion pulse
//   dma_grant                       DMA owns the port (BUSY or DONE)
//   mem_read, mem_write             memory strobes
//   mem_addr, mem_wdata, mem_rdata  memory address and data
module mem_port_arbiter #(
   parameter int WORD_SIZE   = mem_port_arbiter_pkg::WORD_SIZE,
   parameter int MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   output logic                 cpu_ready,
   input  logic                 dma_req,
   input  logic                 dma_we,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [WORD_SIZE-1:0] dma_wdata,
   output logic [WORD_SIZE-1:0] dma_rdata,
   output logic                 dma_ready,
   output logic                 dma_grant,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   import mem_port_arbiter_pkg::*;

   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   arb_state_t           state;
   logic [3:0]           cnt;
   owner_t               owner_q;
   logic                 we_q;
   logic                 any_req;
   owner_t               winner;
   logic                 sel_we;
   logic [WORD_SIZE-1:0] sel_addr;
   logic [WORD_SIZE-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
   owner_t               last_owner;
`endif

   mem_arb_pick u_pick (
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
`ifdef MEM_ARB_RR_EN
      .last_owner (last_owner),
`endif
      .any_req    (any_req),
      .winner     (winner)
   );

   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (winner == OWN_DMA) begin
         sel_we    = dma_we;
         sel_addr  = dma_addr;
         sel_wdata = dma_wdata;
      end
   end

   // mem_addr/mem_wdata double as the latched access registers: loaded on
   // grant, held through BUSY, cleared on leaving BUSY.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         cnt       <= '0;
         owner_q   <= OWN_CPU;
         we_q      <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         dma_grant <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
`ifdef MEM_ARB_RR_EN
         last_owner <= OWN_DMA;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  state     <= ARB_BUSY;
                  cnt       <= '0;
                  owner_q   <= winner;
                  we_q      <= sel_we;
                  mem_read  <= ~sel_we;
                  mem_write <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  dma_grant <= (winner == OWN_DMA);
`ifdef MEM_ARB_RR_EN
                  last_owner <= winner;
`endif
               end
            end
            ARB_BUSY: begin
               if (cnt == LAST_CNT) begin
                  state     <= ARB_DONE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  if (owner_q == OWN_DMA) begin
                     dma_ready <= 1'b1;
                     if (!we_q) dma_rdata <= mem_rdata;
                  end else begin
                     cpu_ready <= 1'b1;
                     if (!we_q) cpu_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ARB_DONE: begin
               state     <= ARB_IDLE;
               cpu_ready <= 1'b0;
               dma_ready <= 1'b0;
               dma_grant <= 1'b0;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
